// File: rtl/response_reorder_unit.sv
// Response reorder buffer: responses tagged with {row,col} unique IDs are parked per slot and
// released per row in allocation order, rows arbitrated round-robin with a stable output lock.
module response_reorder_unit #(
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_ROWS   = 4,
    parameter int NUM_COLS   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alloc_fire,
    input  logic [ID_WIDTH-1:0]   alloc_uid,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ID_WIDTH-1:0]   in_uid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [1:0]            in_resp,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ID_WIDTH-1:0]   out_id,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [1:0]            out_resp,
    output logic                  free_req,
    output logic [ID_WIDTH-1:0]   unique_id_to_free,
    input  logic [ID_WIDTH-1:0]   restored_id
);
    localparam int ROW_W     = $clog2(NUM_ROWS);
    localparam int COL_W     = $clog2(NUM_COLS);
    localparam int UID_W     = ROW_W + COL_W;
    localparam int NUM_SLOTS = NUM_ROWS * NUM_COLS;
    localparam int CNT_W     = $clog2(NUM_COLS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NUM_COLS);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + CNT_W'(1);
    endfunction

    function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] c);
        return (c == '0) ? c : c - CNT_W'(1);
    endfunction

    logic [NUM_SLOTS-1:0]  slot_vld;
    logic [DATA_WIDTH-1:0] slot_data [NUM_SLOTS];
    logic [1:0]            slot_resp [NUM_SLOTS];

    logic [COL_W-1:0]      head [NUM_ROWS];
    logic [CNT_W-1:0]      cnt  [NUM_ROWS];
    logic                  lock;
    logic [ROW_W-1:0]      locked_row;
    logic [ROW_W-1:0]      rr_ptr;

    logic [UID_W-1:0]      in_idx;
    logic                  in_fire;
    logic [ROW_W-1:0]      alloc_row;
    logic [NUM_ROWS-1:0]   eligible;
    logic                  rr_found;
    logic [ROW_W-1:0]      rr_row;
    logic [ROW_W-1:0]      sel_row;
    logic [UID_W-1:0]      sel_idx;
    logic                  fire;
    logic [NUM_ROWS-1:0]   row_inc;
    logic [NUM_ROWS-1:0]   row_dec;
    logic                  unused_ok;

    // Upper ID bits carry no slot information; alloc column is implied by the row head.
    assign unused_ok = ^{in_uid, alloc_uid};

    assign in_idx    = in_uid[UID_W-1:0];
    assign alloc_row = alloc_uid[UID_W-1:COL_W];
    assign in_ready  = ~slot_vld[in_idx];
    assign in_fire   = in_valid & in_ready;

    always_comb begin
        eligible = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            eligible[r] = slot_vld[{ROW_W'(r), head[r]}];
        end
    end

    always_comb begin
        logic [ROW_W-1:0] cand;
        rr_found = 1'b0;
        rr_row   = '0;
        cand     = rr_ptr;
        for (int i = 0; i < NUM_ROWS; i++) begin
            cand = rr_ptr + ROW_W'(i);
            if (!rr_found && eligible[cand]) begin
                rr_found = 1'b1;
                rr_row   = cand;
            end
        end
    end

    // A locked row is always still eligible: its head slot can neither be cleared nor rewritten.
    assign sel_row   = lock ? locked_row : rr_row;
    assign sel_idx   = {sel_row, head[sel_row]};
    assign out_valid = ~rst & (lock | rr_found);
    assign out_data  = slot_data[sel_idx];
    assign out_resp  = slot_resp[sel_idx];
    assign out_id    = restored_id;
    assign fire      = out_valid & out_ready;
    assign free_req  = fire;
    assign unique_id_to_free = out_valid ? ID_WIDTH'(sel_idx) : '0;

    always_comb begin
        row_inc = '0;
        row_dec = '0;
        if (alloc_fire) row_inc[alloc_row] = 1'b1;
        if (fire)       row_dec[sel_row]   = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_vld   <= '0;
            lock       <= 1'b0;
            locked_row <= '0;
            rr_ptr     <= '0;
            for (int r = 0; r < NUM_ROWS; r++) begin
                head[r] <= '0;
                cnt[r]  <= '0;
            end
        end else begin
            if (fire)    slot_vld[sel_idx] <= 1'b0;
            if (in_fire) slot_vld[in_idx]  <= 1'b1;

            if (fire) begin
                lock   <= 1'b0;
                rr_ptr <= sel_row + ROW_W'(1);
            end else if (out_valid) begin
                lock       <= 1'b1;
                locked_row <= sel_row;
            end

            for (int r = 0; r < NUM_ROWS; r++) begin
                if (row_inc[r] && !row_dec[r]) begin
                    cnt[r] <= sat_inc(cnt[r]);
                end else if (row_dec[r] && !row_inc[r]) begin
                    cnt[r] <= sat_dec(cnt[r]);
                end
                // Last outstanding ID of a row unbinds it, so the allocator restarts at column 0.
                if (row_dec[r]) begin
                    head[r] <= (cnt[r] == CNT_W'(1)) ? '0 : head[r] + COL_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire) begin
            slot_data[in_idx] <= in_data;
            slot_resp[in_idx] <= in_resp;
        end
    end

endmodule

// File: tb/tb_response_reorder_unit.sv
// Directed bench for response_reorder_unit: ordering within a row, row round-robin,
// output hold, row unbind, concurrent write/release and mid-transfer reset.
module tb_response_reorder_unit;
    logic        clk;
    logic        rst;
    logic        alloc_fire;
    logic [3:0]  alloc_uid;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_uid;
    logic [31:0] in_data;
    logic [1:0]  in_resp;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_id;
    logic [31:0] out_data;
    logic [1:0]  out_resp;
    logic        free_req;
    logic [3:0]  unique_id_to_free;
    logic [3:0]  restored_id;

    int passed = 0;
    int total  = 0;

    // Allocator model: original ID is a fixed scramble of the unique ID.
    assign restored_id = unique_id_to_free ^ 4'hC;

    response_reorder_unit #(
        .ID_WIDTH(4), .DATA_WIDTH(32), .NUM_ROWS(4), .NUM_COLS(4)
    ) dut (
        .clk(clk), .rst(rst),
        .alloc_fire(alloc_fire), .alloc_uid(alloc_uid),
        .in_valid(in_valid), .in_ready(in_ready), .in_uid(in_uid),
        .in_data(in_data), .in_resp(in_resp),
        .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
        .out_data(out_data), .out_resp(out_resp),
        .free_req(free_req), .unique_id_to_free(unique_id_to_free),
        .restored_id(restored_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
        alloc_fire = 1'b0;
        in_valid   = 1'b0;
    endtask

    task automatic do_alloc(input logic [3:0] uid);
        alloc_fire = 1'b1;
        alloc_uid  = uid;
        tick();
    endtask

    task automatic do_write(input logic [3:0] uid, input logic [31:0] d, input logic [1:0] r);
        in_valid = 1'b1;
        in_uid   = uid;
        in_data  = d;
        in_resp  = r;
        tick();
    endtask

    task automatic apply_reset();
        rst       = 1'b1;
        out_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        in_uid = 4'h0;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passed++;
        total++; if (free_req !== 1'b0) $display("FAIL reset_free_req: got %b want 0", free_req); else passed++;
        total++; if (unique_id_to_free !== 4'h0) $display("FAIL reset_uid_to_free: got %h want 0", unique_id_to_free); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else passed++;
    endtask

    task automatic test_reorder_row0();
        out_ready = 1'b1;
        do_alloc(4'h0);
        do_alloc(4'h1);
        do_write(4'h1, 32'h1111_1111, 2'b00);
        @(negedge clk);
        total++; if (out_valid !== 1'b0) $display("FAIL row0_hold_valid: got %b want 0", out_valid); else passed++;
        total++; if (in_ready !== 1'b0) $display("FAIL row0_busy_in_ready: got %b want 0", in_ready); else passed++;
        do_write(4'h0, 32'h0000_0A0A, 2'b01);
        @(negedge clk);
        total++; if (out_valid !== 1'b1) $display("FAIL row0_first_valid: got %b want 1", out_valid); else passed++;
        total++; if (free_req !== 1'b1) $display("FAIL row0_first_free: got %b want 1", free_req); else passed++;
        total++; if (unique_id_to_free !== 4'h0) $display("FAIL row0_first_uid: got %h want 0", unique_id_to_free); else passed++;
        total++; if (out_id !== 4'hC) $display("FAIL row0_first_id: got %h want c", out_id); else passed++;
        total++; if (out_data !== 32'h0000_0A0A) $display("FAIL row0_first_data: got %h want 00000a0a", out_data); else passed++;
        total++; if (out_resp !== 2'b01) $display("FAIL row0_first_resp: got %b want 01", out_resp); else passed++;
        tick();
        @(negedge clk);
        total++; if (out_valid !== 1'b1) $display("FAIL row0_second_valid: got %b want 1", out_valid); else passed++;
        total++; if (free_req !== 1'b1) $display("FAIL row0_second_free: got %b want 1", free_req); else passed++;
        total++; if (unique_id_to_free !== 4'h1) $display("FAIL row0_second_uid: got %h want 1", unique_id_to_free); else passed++;
        total++; if (out_id !== 4'hD) $display("FAIL row0_second_id: got %h want d", out_id); else passed++;
        total++; if (out_data !== 32'h1111_1111) $display("FAIL row0_second_data: got %h want 11111111", out_data); else passed++;
        tick();
        @(negedge clk);
        total++; if (out_valid !== 1'b0) $display("FAIL row0_drained_valid: got %b want 0", out_valid); else passed++;
        total++; if (free_req !== 1'b0) $display("FAIL row0_drained_free: got %b want 0", free_req); else passed++;
    endtask

    task automatic test_round_robin();
        apply_reset();
        do_alloc(4'h0);
        do_alloc(4'h4);
        do_alloc(4'h8);
        do_write(4'h0, 32'hA0, 2'b00);
        do_write(4'h4, 32'hA4, 2'b00);
        do_write(4'h8, 32'hA8, 2'b00);
        @(negedge clk);
        total++; if (unique_id_to_free !== 4'h0) $display("FAIL rr_first_uid: got %h want 0", unique_id_to_free); else passed++;
        out_ready = 1'b1;
        tick();
        @(negedge clk);
        total++; if (unique_id_to_free !== 4'h4 || free_req !== 1'b1) $display("FAIL rr_second_uid: got %h/%b want 4/1", unique_id_to_free, free_req); else passed++;
        alloc_fire = 1'b1; alloc_uid = 4'h0;
        in_valid = 1'b1; in_uid = 4'h0; in_data = 32'hB0; in_resp = 2'b00;
        tick();
        @(negedge clk);
        total++; if (unique_id_to_free !== 4'h8 || free_req !== 1'b1) $display("FAIL rr_third_uid: got %h/%b want 8/1", unique_id_to_free, free_req); else passed++;
        alloc_fire = 1'b1; alloc_uid = 4'hC;
        in_valid = 1'b1; in_uid = 4'hC; in_data = 32'hBC; in_resp = 2'b11;
        tick();
        @(negedge clk);
        total++; if (unique_id_to_free !== 4'hC) $display("FAIL rr_ptr3_uid: got %h want c", unique_id_to_free); else passed++;
        total++; if (out_data !== 32'hBC) $display("FAIL rr_ptr3_data: got %h want bc", out_data); else passed++;
        tick();
        @(negedge clk);
        total++; if (unique_id_to_free !== 4'h0 || out_valid !== 1'b1) $display("FAIL rr_wrap_uid: got %h/%b want 0/1", unique_id_to_free, out_valid); else passed++;
        total++; if (out_data !== 32'hB0) $display("FAIL rr_wrap_data: got %h want b0", out_data); else passed++;
        tick();
        @(negedge clk);
        total++; if (out_valid !== 1'b0) $display("FAIL rr_drained_valid: got %b want 0", out_valid); else passed++;
    endtask

    task automatic test_hold_stable();
        apply_reset();
        do_alloc(4'h4);
        do_alloc(4'h0);
        do_write(4'h4, 32'h44, 2'b10);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++; if (out_valid !== 1'b1 || unique_id_to_free !== 4'h4) $display("FAIL hold_uid_%0d: got %b/%h want 1/4", i, out_valid, unique_id_to_free); else passed++;
            total++; if (out_id !== 4'h8 || out_data !== 32'h44) $display("FAIL hold_payload_%0d: got %h/%h want 8/44", i, out_id, out_data); else passed++;
            if (i == 1) begin
                in_valid = 1'b1; in_uid = 4'h0; in_data = 32'h00; in_resp = 2'b00;
            end
            tick();
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        total++; if (free_req !== 1'b1 || unique_id_to_free !== 4'h4) $display("FAIL hold_release_row1: got %b/%h want 1/4", free_req, unique_id_to_free); else passed++;
        tick();
        @(negedge clk);
        total++; if (free_req !== 1'b1 || unique_id_to_free !== 4'h0) $display("FAIL hold_release_row0: got %b/%h want 1/0", free_req, unique_id_to_free); else passed++;
        tick();
        @(negedge clk);
        total++; if (out_valid !== 1'b0) $display("FAIL hold_drained_valid: got %b want 0", out_valid); else passed++;
    endtask

    task automatic test_single_outstanding();
        out_ready = 1'b1;
        do_alloc(4'h8);
        do_alloc(4'h9);
        do_write(4'h8, 32'h88, 2'b00);
        @(negedge clk);
        total++; if (free_req !== 1'b1 || unique_id_to_free !== 4'h8) $display("FAIL row2_first: got %b/%h want 1/8", free_req, unique_id_to_free); else passed++;
        tick();
        do_write(4'h9, 32'h99, 2'b00);
        @(negedge clk);
        total++; if (free_req !== 1'b1 || unique_id_to_free !== 4'h9) $display("FAIL row2_last: got %b/%h want 1/9", free_req, unique_id_to_free); else passed++;
        total++; if (out_data !== 32'h99) $display("FAIL row2_last_data: got %h want 99", out_data); else passed++;
        tick();
        do_alloc(4'h8);
        do_write(4'h8, 32'h8888, 2'b01);
        @(negedge clk);
        total++; if (out_valid !== 1'b1 || unique_id_to_free !== 4'h8) $display("FAIL row2_rebind: got %b/%h want 1/8", out_valid, unique_id_to_free); else passed++;
        total++; if (out_data !== 32'h8888) $display("FAIL row2_rebind_data: got %h want 8888", out_data); else passed++;
        tick();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        do_alloc(4'h4);
        do_alloc(4'h5);
        do_write(4'h4, 32'h4444, 2'b01);
        tick();
        @(negedge clk);
        out_ready = 1'b1;
        in_valid = 1'b1; in_uid = 4'h5; in_data = 32'h5555; in_resp = 2'b11;
        #1;
        total++; if (free_req !== 1'b1 || unique_id_to_free !== 4'h4) $display("FAIL b2b_release: got %b/%h want 1/4", free_req, unique_id_to_free); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL b2b_in_ready: got %b want 1", in_ready); else passed++;
        tick();
        @(negedge clk);
        total++; if (out_valid !== 1'b1 || unique_id_to_free !== 4'h5) $display("FAIL b2b_next_uid: got %b/%h want 1/5", out_valid, unique_id_to_free); else passed++;
        total++; if (out_data !== 32'h5555 || out_resp !== 2'b11) $display("FAIL b2b_next_payload: got %h/%b want 5555/11", out_data, out_resp); else passed++;
        tick();
        @(negedge clk);
        total++; if (out_valid !== 1'b0) $display("FAIL b2b_drained_valid: got %b want 0", out_valid); else passed++;
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        do_alloc(4'h0);
        do_alloc(4'h4);
        do_alloc(4'h8);
        do_write(4'h0, 32'hC0, 2'b00);
        do_write(4'h4, 32'hC4, 2'b00);
        do_write(4'h8, 32'hC8, 2'b00);
        @(negedge clk);
        total++; if (out_valid !== 1'b1) $display("FAIL rstmid_pre_valid: got %b want 1", out_valid); else passed++;
        rst = 1'b1;
        out_ready = 1'b1;
        in_uid = 4'h4;
        #1;
        total++; if (free_req !== 1'b0) $display("FAIL rstmid_during_free: got %b want 0", free_req); else passed++;
        tick();
        rst = 1'b0;
        @(negedge clk);
        total++; if (out_valid !== 1'b0) $display("FAIL rstmid_out_valid: got %b want 0", out_valid); else passed++;
        total++; if (free_req !== 1'b0) $display("FAIL rstmid_free_req: got %b want 0", free_req); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL rstmid_in_ready: got %b want 1", in_ready); else passed++;
        total++; if (unique_id_to_free !== 4'h0) $display("FAIL rstmid_uid: got %h want 0", unique_id_to_free); else passed++;
        tick();
        @(negedge clk);
        total++; if (out_valid !== 1'b0 || free_req !== 1'b0) $display("FAIL rstmid_later: got %b/%b want 0/0", out_valid, free_req); else passed++;
    endtask

    initial begin
        rst        = 1'b1;
        alloc_fire = 1'b0;
        alloc_uid  = 4'h0;
        in_valid   = 1'b0;
        in_uid     = 4'h0;
        in_data    = 32'h0;
        in_resp    = 2'b00;
        out_ready  = 1'b0;
        tick();
        test_reset();
        test_reorder_row0();
        test_round_robin();
        test_hold_stable();
        test_single_outstanding();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/response_reorder_unit.md
RESPONSE_REORDER_UNIT -- requirements
Module: response_reorder_unit

Interface
REQ-001 Parameter ID_WIDTH, default 4, width of original and unique IDs.
REQ-002 Parameter DATA_WIDTH, default 32, response payload width.
REQ-003 Parameter NUM_ROWS, default 4, rows of the unique-ID space (power of 2); ROW_W = clog2(NUM_ROWS).
REQ-004 Parameter NUM_COLS, default 4, columns per row (power of 2); COL_W = clog2(NUM_COLS); ROW_W+COL_W <= ID_WIDTH.
REQ-005 clk  input  1  clock; all state updates on posedge clk.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 alloc_fire  input  1  a unique ID was granted this cycle.
REQ-008 alloc_uid  input  ID_WIDTH  the granted unique ID, {row,col} in the low ROW_W+COL_W bits.
REQ-009 in_valid / in_ready  input / output  1  response-in handshake, transfer when both high.
REQ-010 in_uid  input  ID_WIDTH  unique ID carried by the incoming response.
REQ-011 in_data  input  DATA_WIDTH / in_resp  input  2  response payload and status.
REQ-012 out_valid / out_ready  output / input  1  response-out handshake.
REQ-013 out_id  output  ID_WIDTH  original ID of the released response, equal to restored_id.
REQ-014 out_data  output  DATA_WIDTH / out_resp  output  2  released payload and status.
REQ-015 free_req  output  1  release of one unique ID this cycle.
REQ-016 unique_id_to_free  output  ID_WIDTH  released unique ID, zero-padded above ROW_W+COL_W.
REQ-017 restored_id  input  ID_WIDTH  original ID for unique_id_to_free, combinational from the allocator in the same cycle.

Function
REQ-018 Storage SHALL be one slot per {row,col}, each holding valid, data and resp; bits of in_uid and alloc_uid above ROW_W+COL_W SHALL be ignored.
REQ-019 in_ready SHALL be high when the slot addressed by in_uid is not valid.
REQ-020 On an input handshake, the addressed slot SHALL become valid and capture in_data and in_resp at the next edge.
REQ-021 Each row SHALL have a head pointer (COL_W bits) and an outstanding counter (clog2(NUM_COLS+1) bits).
REQ-022 On alloc_fire, the counter of the alloc_uid row SHALL increment.
REQ-023 On each release, the counter of the released row SHALL decrement.
REQ-024 When alloc_fire and a release hit the same row in the same cycle, that row's counter SHALL hold.
REQ-025 A row SHALL be eligible when slot[row][head[row]] is valid.
REQ-026 When not locked, selection SHALL be round-robin: the first eligible row searching upward from rr_ptr, with wrap-around.
REQ-027 out_valid SHALL be high whenever a row is selected; out_data and out_resp SHALL come from the head slot of that row.
REQ-028 Once out_valid is high without out_ready, the selected row and all outputs SHALL stay stable until a handshake, using a lock flag and locked_row register.
REQ-029 On a handshake (out_valid & out_ready), in the same cycle: free_req=1 and unique_id_to_free={row,head[row]}.
REQ-030 On that handshake, at the next edge: the slot is cleared, the lock is cleared, and rr_ptr becomes row+1 mod NUM_ROWS.
REQ-031 On that handshake, head[row] SHALL increment mod NUM_COLS, unless the row counter equals 1, in which case head[row] SHALL reset to 0, matching the allocator's unbind rule.
REQ-032 free_req SHALL be 0 in every cycle without an output handshake; at most one release per cycle.
REQ-033 Minimum latency SHALL be 1 cycle: a response written at edge N can appear on out_valid at the earliest in cycle N+1; there is no input-to-output bypass.
REQ-034 An input write and a release of a different slot in the same cycle SHALL both take effect.
REQ-035 Same-slot write/release collisions cannot occur because in_ready is low for valid slots.
REQ-036 A counter decrement below 0 or increment above NUM_COLS is a protocol error, and counters SHALL saturate.

Reset
REQ-037 While rst=1, every slot valid bit, head, counter, lock flag and rr_ptr SHALL clear to 0 at the edge.
REQ-038 After reset, out_valid=0, free_req=0 and unique_id_to_free=0; in_ready is then determined by slot valid bits, so it is 1.
REQ-039 rst asserted mid-transfer SHALL discard all buffered responses, with no free_req issued for them.

Verification
REQ-040 Allocate uid 0x0,0x1 (row 0), return 0x1 then 0x0 -> 0x1 held (out_valid=0) until 0x0 arrives; then outputs 0x0, 0x1 on consecutive handshakes, each with free_req and matching unique_id_to_free.
REQ-041 Responses for rows 0,1,2 all eligible, out_ready=1 -> released in row order 0,1,2, then rr_ptr=3.
REQ-042 out_ready=0 for 5 cycles with row 1 eligible, then row 0 becomes eligible -> out_id, out_data and unique_id_to_free stay on row 1 until the handshake.
REQ-043 Row 2 with one outstanding (uid 0x9), released -> head[2]=0, next alloc 0x8 returned -> released.
REQ-044 Input write to uid 0x5 in the same cycle as release of 0x4 -> both complete; 0x5 releases the next cycle.
REQ-045 rst pulse with 3 buffered responses -> out_valid=0, free_req=0, in_ready=1 the cycle after.
